gate_array_pipe: RTL



---
 rtl/gate_array_pkg.sv | 30 +++
 rtl/gate_array_pipe_op.sv | 34 +++
 rtl/gate_array_pipe.sv | 96 +++++++++
 3 files changed

// File: rtl/gate_array_pkg.sv
// Shared types for the pipelined bitwise gate unit.
// Op codes, parameter limits and the stage bundle.
package gate_array_pkg;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 4;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_NAND = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  // y is sized for the widest build; narrower
  // builds keep the upper bits at zero.
  typedef struct packed {
    logic                 valid;
    logic [WIDTH_MAX-1:0] y;
    logic                 zero;
    logic                 ones;
  } stage_t;

endpackage

// File: rtl/gate_array_pipe_op.sv
// Combinational WIDTH-bit gate with zero/ones flags.
// Used once, in stage 0 of gate_array_pipe.
module gate_op_unit
  import gate_array_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ones
);

  // Select the gate function; NOT A and PASS A ignore b.
  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_NAND: y = ~(a & b);
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOTA: y = ~a;
      OP_PASS: y = a;
    endcase
  end

  assign zero = ~|y;
  assign ones = &y;

endmodule

// File: rtl/gate_array_pipe.sv
// Pipelined bitwise gate unit with accumulator feedback.
// Valid/ready stream in, DEPTH-stage shift pipe out.
module gate_array_pipe
  import gate_array_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_ones,
  output logic [15:0]      beat_cnt
);

  logic             en;
  logic             accept;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] y0;
  logic             z0;
  logic             o0;
  logic [WIDTH_MAX-1:0] y0_ext;
  stage_t           s0;
  stage_t           pipe [1:DEPTH];
  logic             unused_hi;

  // Whole pipe moves together; ready mirrors it.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && in_ready;
  assign opa      = in_use_acc ? acc : in_a;

  gate_op_unit #(
    .WIDTH(WIDTH)
  ) u_op (
    .a    (opa),
    .b    (in_b),
    .op   (op_e'(in_op)),
    .y    (y0),
    .zero (z0),
    .ones (o0)
  );

  // Widen the stage-0 result into the stage bundle.
  always_comb begin
    y0_ext = '0;
    y0_ext[WIDTH-1:0] = y0;
    s0 = '{valid: accept, y: y0_ext,
           zero: z0, ones: o0};
  end

  // Shift register of stages; bubbles enter when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= DEPTH; i++)
        pipe[i] <= '0;
    end else if (en) begin
      pipe[1] <= s0;
      for (int i = 2; i <= DEPTH; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  // Accumulator follows every accepted result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (accept)
      acc <= y0;
  end

  // Free-running count of accepted beats, wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      beat_cnt <= '0;
    else if (accept)
      beat_cnt <= beat_cnt + 16'd1;
  end

  assign out_valid = pipe[DEPTH].valid;
  assign out_y     = pipe[DEPTH].y[WIDTH-1:0];
  assign out_zero  = pipe[DEPTH].zero;
  assign out_ones  = pipe[DEPTH].ones;
  assign unused_hi = ^pipe[DEPTH].y;

endmodule
